// File: rtl/program_encoder.sv
// Packs structured instruction requests into 32-bit ARM words and writes them
// sequentially into instruction memory, closing each program with a halt word.
module program_encoder #(
    parameter int          ADDR_W    = 6,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] HALT_WORD = 32'hEAFFFFFE
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              Start,
    input  logic              Finish,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [3:0]        ReqCond,
    input  logic [1:0]        ReqOp,
    input  logic [5:0]        ReqFunct,
    input  logic [3:0]        ReqRn,
    input  logic [3:0]        ReqRd,
    input  logic [11:0]       ReqSrc2,
    input  logic [23:0]       ReqImm24,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWD,
    output logic [ADDR_W:0]   WordCount,
    output logic              Done,
    output logic              Err
);
    typedef enum logic [1:0] {IDLE, LOAD, HALT, DONE} state_t;

    // Last slot is held back so the halt word always fits.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;
    logic                we_n, done_n, err_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [31:0]         wd_n, word;
    logic [ADDR_W:0]     cnt_n;
    logic                accept;

    assign ReqReady = (state == LOAD) && ({1'b0, ptr} < LAST);
    assign accept   = ReqValid & ReqReady;

    always_comb begin
        if (ReqOp == 2'b10)
            word = {ReqCond, ReqOp, ReqFunct[5:4], ReqImm24};
        else
            word = {ReqCond, ReqOp, ReqFunct, ReqRn, ReqRd, ReqSrc2};
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        we_n    = 1'b0;
        addr_n  = MemAddr;
        wd_n    = MemWD;
        cnt_n   = WordCount;
        done_n  = Done;
        err_n   = Err;
        // Start overrides everything, including an accept in the same cycle.
        if (Start) begin
            state_n = LOAD;
            ptr_n   = '0;
            cnt_n   = '0;
            done_n  = 1'b0;
            err_n   = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (ReqOp == 2'b11) begin
                            err_n = 1'b1;
                        end else begin
                            we_n   = 1'b1;
                            addr_n = ptr;
                            wd_n   = word;
                            ptr_n  = ptr + 1'b1;
                            cnt_n  = WordCount + 1'b1;
                        end
                    end
                    if (Finish) state_n = HALT;
                end
                HALT: begin
                    we_n    = 1'b1;
                    addr_n  = ptr;
                    wd_n    = HALT_WORD;
                    cnt_n   = WordCount + 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            MemWE     <= 1'b0;
            MemAddr   <= '0;
            MemWD     <= '0;
            WordCount <= '0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            MemWE     <= we_n;
            MemAddr   <= addr_n;
            MemWD     <= wd_n;
            WordCount <= cnt_n;
            Done      <= done_n;
            Err       <= err_n;
        end
    end
endmodule

// File: tb/tb_program_encoder.sv
// Bench for program_encoder: table vectors, directed corner sequences and
// random traffic, all checked against a transaction-level model.
module tb_program_encoder;
    localparam int          ADDR_W = 6;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] HALT   = 32'hEAFFFFFE;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } req_t;

    typedef struct packed {
        req_t        r;
        logic [31:0] word;
    } vec_t;

    logic              CLK, nRESET, Start, Finish, ReqValid, ReqReady;
    logic [3:0]        ReqCond, ReqRn, ReqRd;
    logic [1:0]        ReqOp;
    logic [5:0]        ReqFunct;
    logic [11:0]       ReqSrc2;
    logic [23:0]       ReqImm24;
    logic              MemWE, Done, Err;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWD;
    logic [ADDR_W:0]   WordCount;

    program_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .CLK(CLK), .nRESET(nRESET), .Start(Start), .Finish(Finish),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqCond(ReqCond), .ReqOp(ReqOp),
        .ReqFunct(ReqFunct), .ReqRn(ReqRn), .ReqRd(ReqRd), .ReqSrc2(ReqSrc2),
        .ReqImm24(ReqImm24), .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD),
        .WordCount(WordCount), .Done(Done), .Err(Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // model state: program open for requests, halt pending, flags, next write
    logic        open, halting, mdone, merr, exp_we;
    int          mptr, mcnt;
    logic [31:0] exp_addr, exp_wd;
    req_t        z;
    vec_t        tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input req_t r);
        if (r.op == 2'd2) return {r.cond, r.op, r.funct[5:4], r.imm24};
        return {r.cond, r.op, r.funct, r.rn, r.rd, r.src2};
    endfunction

    function automatic req_t rand_req(input logic ill);
        req_t r;
        r = req_t'({$urandom, $urandom, $urandom});
        r.op = ill ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic model_reset();
        open = 0; halting = 0; mdone = 0; merr = 0; exp_we = 0;
        mptr = 0; mcnt = 0; exp_addr = 0; exp_wd = 0;
    endtask

    // One clock: check what the previous edge produced, drive, predict the next edge.
    task automatic cyc(input logic v, input req_t r, input logic st, input logic fin,
                       input logic [31:0] wexp);
        logic rdy;
        @(negedge CLK);
        chk("MemWE", {31'd0, MemWE}, {31'd0, exp_we});
        if (exp_we) begin
            chk("MemAddr", 32'(MemAddr), exp_addr);
            chk("MemWD", MemWD, exp_wd);
        end
        chk("WordCount", 32'(WordCount), 32'(mcnt));
        chk("Done", {31'd0, Done}, {31'd0, mdone});
        chk("Err", {31'd0, Err}, {31'd0, merr});
        Start = st; Finish = fin; ReqValid = v;
        ReqCond = r.cond; ReqOp = r.op; ReqFunct = r.funct; ReqRn = r.rn;
        ReqRd = r.rd; ReqSrc2 = r.src2; ReqImm24 = r.imm24;
        #1;
        rdy = open && (mptr < DEPTH - 1);
        chk("ReqReady", {31'd0, ReqReady}, {31'd0, rdy});
        exp_we = 0;
        if (st) begin
            open = 1; halting = 0; mdone = 0; merr = 0; mptr = 0; mcnt = 0;
        end else if (halting) begin
            exp_we = 1; exp_addr = 32'(mptr); exp_wd = HALT;
            mcnt++; halting = 0; mdone = 1;
        end else if (open) begin
            if (v && rdy) begin
                if (r.op == 2'd3) merr = 1;
                else begin
                    exp_we = 1; exp_addr = 32'(mptr); exp_wd = wexp;
                    mptr++; mcnt++;
                end
            end
            if (fin) begin open = 0; halting = 1; end
        end
        @(posedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, z, 0, 0, 0);
    endtask

    task automatic rnd(input logic v, input logic st, input logic fin, input logic ill);
        req_t r;
        r = rand_req(ill);
        cyc(v, r, st, fin, enc(r));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_we"}, {31'd0, MemWE}, 0);
        chk({nm, "_addr"}, 32'(MemAddr), 0);
        chk({nm, "_wd"}, MemWD, 0);
        chk({nm, "_cnt"}, 32'(WordCount), 0);
        chk({nm, "_done"}, {31'd0, Done}, 0);
        chk({nm, "_err"}, {31'd0, Err}, 0);
        chk({nm, "_rdy"}, {31'd0, ReqReady}, 0);
    endtask

    initial begin
        z = '0;
        tbl[0] = '{r: '{4'hE, 2'd0, 6'b101000, 4'd1, 4'd2, 12'h005, 24'h0}, word: 32'hE2812005};
        tbl[1] = '{r: '{4'hE, 2'd2, 6'b100000, 4'd0, 4'd0, 12'h000, 24'h000003}, word: 32'hEA000003};
        tbl[2] = '{r: '{4'h0, 2'd1, 6'b011001, 4'd3, 4'd4, 12'h010, 24'h0}, word: 32'h05934010};
        tbl[3] = '{r: '{4'hE, 2'd3, 6'b000000, 4'd5, 4'd6, 12'h123, 24'h0}, word: 32'h0};
        tbl[4] = '{r: '{4'hB, 2'd2, 6'b110000, 4'd7, 4'd7, 12'hFFF, 24'hFFFFFE}, word: 32'hBBFFFFFE};
        tbl[5] = '{r: '{4'hA, 2'd0, 6'b010010, 4'hF, 4'h0, 12'hABC, 24'h0}, word: 32'hA12F0ABC};

        nRESET = 0; Start = 0; Finish = 0; ReqValid = 0;
        ReqCond = 0; ReqOp = 0; ReqFunct = 0; ReqRn = 0; ReqRd = 0; ReqSrc2 = 0; ReqImm24 = 0;
        model_reset();
        #12 chk_all_zero("reset");
        @(negedge CLK) nRESET = 1;

        // table program; illegal entry 3 must not consume an address, Finish rides the last accept
        cyc(0, z, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, tbl[i].r, 0, i == 5, tbl[i].word);
        idle(2);
        @(negedge CLK);
        chk("tbl_count", 32'(WordCount), 6);
        chk("tbl_done", {31'd0, Done}, 1);
        chk("tbl_err", {31'd0, Err}, 1);

        // restart clears Err; branch then a lone Finish
        cyc(0, z, 1, 0, 0);
        cyc(1, tbl[1].r, 0, 0, tbl[1].word);
        cyc(0, z, 0, 1, 0);
        idle(2);
        @(negedge CLK);
        chk("br_count", 32'(WordCount), 2);
        chk("br_done", {31'd0, Done}, 1);
        chk("br_err", {31'd0, Err}, 0);

        // fill to the reserved slot, then halt lands in the last word
        cyc(0, z, 1, 0, 0);
        for (int i = 0; i < DEPTH + 4; i++) rnd(1, 0, 0, 0);
        cyc(1, z, 0, 1, 0);
        idle(2);
        @(negedge CLK);
        chk("full_count", 32'(WordCount), DEPTH);
        chk("full_done", {31'd0, Done}, 1);

        // Start mid-LOAD drops its accept; Start during HALT suppresses the halt
        cyc(0, z, 1, 0, 0);
        rnd(1, 0, 0, 0);
        rnd(1, 1, 0, 0);
        rnd(1, 0, 1, 0);
        cyc(0, z, 1, 0, 0);
        idle(2);

        // Finish ignored in DONE/IDLE-like states; Start beats Finish
        cyc(0, z, 0, 1, 0);
        idle(2);
        cyc(0, z, 0, 1, 0);
        cyc(0, z, 1, 1, 0);
        rnd(1, 0, 0, 0);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++)
            rnd($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 29) == 0, 1);
        idle(3);

        // asynchronous reset mid-LOAD
        cyc(0, z, 1, 0, 0);
        rnd(1, 0, 0, 0);
        rnd(1, 0, 0, 0);
        #3 nRESET = 0;
        #1 chk_all_zero("areset");
        model_reset();
        rnd(1, 0, 0, 0);
        @(negedge CLK) nRESET = 1;
        for (int i = 0; i < 3; i++) rnd(1, 0, 1, 0);
        cyc(0, z, 1, 0, 0);
        cyc(1, tbl[0].r, 0, 1, tbl[0].word);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
